nios_system_block_status: RTL and testbench

Avalon-MM slave input port for the Nios II system: the hardware-to-CPU return path for the block datapath. It samples a WIDTH-bit status bus from fabric logic, presents it for CPU reads, latches per-bit edge events in a write-1-to-clear register and raises a maskable interrupt. It sits on the same system interconnect as the system's write-only output PIOs.

---
 rtl/nios_system_block_status_if.sv | 25 ++
 rtl/nios_system_block_status.sv | 107 ++++++++++
 tb/tb_nios_system_block_status.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_system_block_status_if.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_block_status_if
//  Description : Avalon-MM slave bus and interrupt line for the status port.
//  Revision    : 1.0  initial release
// ============================================================================
interface nios_system_block_status_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface
`default_nettype wire

// File: rtl/nios_system_block_status.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_block_status
//  Description : Avalon-MM status input port with W1C edge capture and a
//                maskable level interrupt. Define
//                NIOS_SYSTEM_BLOCK_STATUS_SYNC_EN for a 2-flop input synchronizer.
//  Revision    : 1.0  initial release
// ============================================================================
module nios_system_block_status #(
    parameter int WIDTH     = 32,
    parameter int EDGE_TYPE = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          in_port,
    nios_system_block_status_if.slave avs
);

`ifdef NIOS_SYSTEM_BLOCK_STATUS_SYNC_EN
    localparam int c_SYNC_STAGES = 2;
`else
    localparam int c_SYNC_STAGES = 0;
`endif
    // Edge detection waits until data_prev holds a genuine sample of in_port.
    localparam int c_PRIME_DEPTH = c_SYNC_STAGES + 2;

    logic [WIDTH-1:0]         w_sample;
    logic [WIDTH-1:0]         r_data_in;
    logic [WIDTH-1:0]         r_data_prev;
    logic [WIDTH-1:0]         r_irq_mask;
    logic [WIDTH-1:0]         r_edge_capture;
    logic [WIDTH-1:0]         w_edge_raw;
    logic [WIDTH-1:0]         w_edge;
    logic [WIDTH-1:0]         w_clear;
    logic [c_PRIME_DEPTH-1:0] r_prime_sr;
    logic                     w_primed;
    logic                     w_wr;
    logic [31:0]              w_readdata;

`ifdef NIOS_SYSTEM_BLOCK_STATUS_SYNC_EN
    logic [WIDTH-1:0] r_sync_0;
    logic [WIDTH-1:0] r_sync_1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_0 <= '0;
            r_sync_1 <= '0;
        end else begin
            r_sync_0 <= in_port;
            r_sync_1 <= r_sync_0;
        end
    end

    assign w_sample = r_sync_1;
`else
    assign w_sample = in_port;
`endif

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge_raw = r_data_in & ~r_data_prev;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge_raw = ~r_data_in & r_data_prev;
        end else begin : g_any
            assign w_edge_raw = r_data_in ^ r_data_prev;
        end
    endgenerate

    assign w_primed = r_prime_sr[c_PRIME_DEPTH-1];
    assign w_edge   = w_primed ? w_edge_raw : '0;
    assign w_wr     = avs.chipselect & ~avs.write_n;
    assign w_clear  = (w_wr && avs.address == 2'd3) ? avs.writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_in      <= '0;
            r_data_prev    <= '0;
            r_prime_sr     <= '0;
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
        end else begin
            r_data_in   <= w_sample;
            r_data_prev <= r_data_in;
            r_prime_sr  <= {r_prime_sr[c_PRIME_DEPTH-2:0], 1'b1};
            if (w_wr && avs.address == 2'd2) begin
                r_irq_mask <= avs.writedata[WIDTH-1:0];
            end
            // A fresh edge overrides a simultaneous clear of the same bit.
            r_edge_capture <= (r_edge_capture & ~w_clear) | w_edge;
        end
    end

    always_comb begin
        w_readdata = '0;
        case (avs.address)
            2'd0:    w_readdata[WIDTH-1:0] = r_data_in;
            2'd2:    w_readdata[WIDTH-1:0] = r_irq_mask;
            2'd3:    w_readdata[WIDTH-1:0] = r_edge_capture;
            default: w_readdata = '0;
        endcase
    end

    assign avs.readdata = w_readdata;
    assign avs.irq      = |(r_edge_capture & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_nios_system_block_status.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios_system_block_status
//  Description : Scoreboard bench for the status port, rising and any-edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nios_system_block_status;

`ifdef NIOS_SYSTEM_BLOCK_STATUS_SYNC_EN
    localparam int N = 2;
`else
    localparam int N = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in0;
    logic [31:0] in2;

    always #5 clk = ~clk;

    nios_system_block_status_if a0 ();
    nios_system_block_status_if a2 ();

    nios_system_block_status #(.WIDTH(32), .EDGE_TYPE(0)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in0),
        .avs     (a0.slave)
    );

    nios_system_block_status #(.WIDTH(32), .EDGE_TYPE(2)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in2),
        .avs     (a2.slave)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(string name, logic [31:0] rd, logic irq,
                         logic [31:0] erd, logic eirq);
        checks++;
        if (rd !== erd || irq !== eirq) begin
            errors++;
            $display("FAIL %s: got readdata=%h irq=%b, expected readdata=%h irq=%b",
                     name, rd, irq, erd, eirq);
        end
    endtask

    task automatic score(logic [1:0] sel, logic [31:0] rd, logic irq);
        exp_t  e;
        string n;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: dut%0d readdata=%h with no expectation", sel, rd);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (e.sel != sel) begin
                checks++;
                errors++;
                $display("FAIL %s: read seen on dut%0d, expected on dut%0d", n, sel, e.sel);
            end else begin
                check(n, rd, irq, e.rd, e.irq);
            end
        end
    endtask

    // Monitor: a read strobe present at the falling edge is a DUT response.
    always @(negedge clk) begin
        if (a0.chipselect && a0.write_n) score(2'd0, a0.readdata, a0.irq);
        if (a2.chipselect && a2.write_n) score(2'd2, a2.readdata, a2.irq);
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(int sel, logic [1:0] addr, logic [31:0] data);
        if (sel == 0) begin
            a0.address = addr; a0.writedata = data; a0.chipselect = 1'b1; a0.write_n = 1'b0;
        end else begin
            a2.address = addr; a2.writedata = data; a2.chipselect = 1'b1; a2.write_n = 1'b0;
        end
        @(posedge clk);
        #1;
        a0.chipselect = 1'b0; a0.write_n = 1'b1;
        a2.chipselect = 1'b0; a2.write_n = 1'b1;
    endtask

    task automatic rd(int sel, logic [1:0] addr, logic [31:0] erd, logic eirq, string name);
        exp_t e;
        e.sel = 2'(sel);
        e.rd  = erd;
        e.irq = eirq;
        exp_q.push_back(e);
        name_q.push_back(name);
        if (sel == 0) begin
            a0.address = addr; a0.chipselect = 1'b1; a0.write_n = 1'b1;
        end else begin
            a2.address = addr; a2.chipselect = 1'b1; a2.write_n = 1'b1;
        end
        @(negedge clk);
        #1;
        a0.chipselect = 1'b0;
        a2.chipselect = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        in0 = 32'hFFFF_FFFF;
        in2 = 32'h0;
        a0.address = 2'd0; a0.chipselect = 1'b0; a0.write_n = 1'b1; a0.writedata = '0;
        a2.address = 2'd0; a2.chipselect = 1'b0; a2.write_n = 1'b1; a2.writedata = '0;

        // Reset state and bus held high through release
        tick(3);
        rd(0, 2'd0, 32'h0, 1'b0, "reset_data");
        rd(0, 2'd3, 32'h0, 1'b0, "reset_edge");
        rd(0, 2'd2, 32'h0, 1'b0, "reset_mask");
        tick(1);
        reset_n = 1'b1;
        wr(0, 2'd2, 32'hFFFF_FFFF);
        tick(N + 3);
        rd(0, 2'd0, 32'hFFFF_FFFF, 1'b0, "prime_data");
        rd(0, 2'd1, 32'h0, 1'b0, "reserved_zero");
        tick(4);
        rd(0, 2'd3, 32'h0, 1'b0, "prime_no_edge");

        // Rising capture with exact latency
        wr(0, 2'd2, 32'h1);
        in0 = 32'h0;
        tick(N + 4);
        rd(0, 2'd3, 32'h0, 1'b0, "fall_ignored");
        tick(1);
        in0 = 32'h1;
        tick(N + 1);
        rd(0, 2'd3, 32'h0, 1'b0, "rise_before");
        tick(1);
        rd(0, 2'd3, 32'h1, 1'b1, "rise_capture");
        rd(0, 2'd0, 32'h1, 1'b1, "rise_data");
        tick(1);
        in0 = 32'h0;
        tick(N + 4);
        rd(0, 2'd3, 32'h1, 1'b1, "rise_then_fall");

        // Write-1-to-clear and mask effect
        tick(1);
        in0 = 32'h4;
        tick(N + 4);
        rd(0, 2'd3, 32'h5, 1'b1, "w1c_before");
        wr(0, 2'd3, 32'h4);
        rd(0, 2'd3, 32'h1, 1'b1, "w1c_after");
        wr(0, 2'd2, 32'h4);
        rd(0, 2'd3, 32'h1, 1'b0, "w1c_mask_off");
        rd(0, 2'd2, 32'h4, 1'b0, "mask_readback");
        tick(1);
        in0 = 32'h0;
        tick(N + 4);

        // Set beats clear on the same cycle
        wr(0, 2'd2, 32'h1);
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, 32'h0, 1'b0, "clear_bit0");
        tick(1);
        in0 = 32'h1;
        tick(N + 1);
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, 32'h1, 1'b1, "set_beats_clear");
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, 32'h0, 1'b0, "clear_again");

        // Asynchronous reset mid-operation
        tick(1);
        in0 = 32'h0;
        tick(N + 4);
        in0 = 32'h1;
        tick(N + 4);
        rd(0, 2'd3, 32'h1, 1'b1, "pre_reset_irq");
        tick(1);
        a0.address = 2'd0; a0.chipselect = 1'b1; a0.write_n = 1'b1;
        #1;
        check("pre_async_data", a0.readdata, a0.irq, 32'h1, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_data", a0.readdata, a0.irq, 32'h0, 1'b0);
        a0.address = 2'd3;
        #1;
        check("async_edge", a0.readdata, a0.irq, 32'h0, 1'b0);
        a0.chipselect = 1'b0;
        tick(2);
        reset_n = 1'b1;
        wr(0, 2'd2, 32'h1);
        tick(N + 6);
        rd(0, 2'd3, 32'h0, 1'b0, "no_capture_after_reset");
        rd(0, 2'd0, 32'h1, 1'b0, "post_reset_data");

        // Any-edge instance
        tick(1);
        in2 = 32'h8;
        tick(4);
        in2 = 32'h0;
        tick(N + 4);
        rd(2, 2'd3, 32'h8, 1'b0, "any_pulse_masked");
        wr(2, 2'd2, 32'h8);
        rd(2, 2'd3, 32'h8, 1'b1, "any_mask_irq");
        wr(2, 2'd3, 32'h8);
        rd(2, 2'd3, 32'h0, 1'b0, "any_clear");
        tick(1);
        in2 = 32'h8;
        tick(N + 4);
        wr(2, 2'd3, 32'h8);
        rd(2, 2'd3, 32'h0, 1'b0, "any_clear_rise");
        tick(1);
        in2 = 32'h0;
        tick(N + 4);
        rd(2, 2'd3, 32'h8, 1'b1, "any_fall");

        tick(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: %0d responses never observed", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
